// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared definitions for the 16-bit processor front end.
//   INSTR_W          - instruction word width
//   OPC_HI/OPC_LO    - opcode field bounds within an instruction
//   FN_HI/FN_LO      - function-code field bounds within an instruction
//   fetch_state_e    - instruction-fetch FSM states
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
package cpu16_pkg;

    localparam int unsigned INSTR_W = 16;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;
    localparam int unsigned FN_HI  = 3;
    localparam int unsigned FN_LO  = 0;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StWait,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory read bus.
//   imem_req   - read request, held with imem_addr stable until imem_ack
//   imem_addr  - word address of the request
//   imem_ack   - read complete, imem_rdata valid this cycle (same-cycle ack allowed)
//   imem_rdata - instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface instr_fetch_if
    import cpu16_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage. Owns the PC, issues one-outstanding reads to
// instruction memory and holds the fetched word in an IF/ID register for decode.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   imem            - instruction-memory bus (master side)
//   redirect_valid  - one-cycle pulse: redirect_pc becomes the next PC, wrong path flushed
//   redirect_pc     - branch/jump target
//   if_valid        - IF/ID register holds a live instruction
//   id_ready        - decode consumes the IF/ID entry this cycle when if_valid
//   if_instr/if_pc  - fetched word and its address
//   if_opcode       - if_instr[15:12], to control_unit.opcode
//   if_funct        - if_instr[3:0], to control_unit.function_code
//   fetch_count     - number of instructions delivered into IF/ID (wraps)
module instr_fetch
    import cpu16_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_if.master      imem,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [3:0]         if_opcode,
    output logic [3:0]         if_funct,
    output logic [15:0]        fetch_count
);

    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [15:0]        fetch_count_q, fetch_count_d;

    logic req;
    logic ack_hit;
    logic redirect;
    logic accept;

    // Redirects are ignored while booting; nothing is in flight yet.
    assign redirect = redirect_valid && (state_q != StBoot);
    assign ack_hit  = req && imem.imem_ack;
    // Words acked in DRAIN or in a redirect cycle belong to the wrong path.
    assign accept   = ack_hit && !redirect && ((state_q == StFetch) || (state_q == StWait));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: begin
                if (req && !imem.imem_ack) begin
                    state_d = redirect ? StDrain : StWait;
                end else begin
                    state_d = StFetch;
                end
            end
            StWait: begin
                if (imem.imem_ack) begin
                    state_d = StFetch;
                end else begin
                    state_d = redirect ? StDrain : StWait;
                end
            end
            StDrain: begin
                if (imem.imem_ack) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    // FSM outputs: memory request and address.
    always_comb begin
        req            = 1'b0;
        imem.imem_addr = pc_q;
        unique case (state_q)
            StBoot:  req = 1'b0;
            StFetch: req = !if_valid_q || id_ready;
            StWait:  req = 1'b1;
            StDrain: begin
                // pc_q may already hold the redirect target; keep the cancelled address.
                req            = 1'b1;
                imem.imem_addr = drain_addr_q;
            end
            default: req = 1'b0;
        endcase
    end

    assign imem.imem_req = req;

    // Datapath next state.
    always_comb begin
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        // Track the live request address until DRAIN freezes it.
        if (state_q != StDrain) begin
            drain_addr_d = pc_q;
        end

        if (redirect) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
        end else if (accept) begin
            pc_d          = pc_q + ADDR_W'(1);
            if_valid_d    = 1'b1;
            if_instr_d    = imem.imem_rdata;
            if_pc_d       = pc_q;
            fetch_count_d = fetch_count_q + 16'd1;
        end else if (if_valid_q && id_ready) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            drain_addr_q  <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_opcode   = if_instr_q[OPC_HI:OPC_LO];
    assign if_funct    = if_instr_q[FN_HI:FN_LO];
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed test of instr_fetch against a simple instruction memory
// with programmable ack latency (0 = same-cycle ack, N = ack in the Nth request cycle).
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [3:0]  if_opcode;
    logic [3:0]  if_funct;
    logic [15:0] fetch_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned mem_lat;
    int unsigned wait_cnt;
    logic [15:0] mem [256];

    instr_fetch_if #(.ADDR_W(16)) imem_bus ();

    instr_fetch #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode),
        .if_funct       (if_funct),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: counts request cycles without ack; acks on cycle mem_lat.
    assign imem_bus.imem_ack   = imem_bus.imem_req && ((mem_lat == 0) || (wait_cnt >= mem_lat - 1));
    assign imem_bus.imem_rdata = mem[imem_bus.imem_addr[7:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (imem_bus.imem_req && !imem_bus.imem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'h0012;
        mem[1] = 16'h3105;
        mem[2] = 16'h4230;

        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        mem_lat        = 0;

        // Reset state
        #2;
        chk("rst_req", 32'(imem_bus.imem_req), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_instr", 32'(if_instr), 32'h0);
        chk("rst_if_pc", 32'(if_pc), 32'h0);
        chk("rst_fetch_count", 32'(fetch_count), 32'h0);

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("boot_req", 32'(imem_bus.imem_req), 32'h0);

        // Zero-wait streaming of addresses 0..2
        tick();
        chk("zw_req0", 32'(imem_bus.imem_req), 32'h1);
        chk("zw_addr0", 32'(imem_bus.imem_addr), 32'h0);
        tick();
        chk("zw_addr1", 32'(imem_bus.imem_addr), 32'h1);
        chk("zw_valid0", 32'(if_valid), 32'h1);
        chk("zw_opc0", 32'(if_opcode), 32'h0);
        chk("zw_fn0", 32'(if_funct), 32'h2);
        tick();
        chk("zw_addr2", 32'(imem_bus.imem_addr), 32'h2);
        chk("zw_opc1", 32'(if_opcode), 32'h3);
        chk("zw_fn1", 32'(if_funct), 32'h5);
        tick();
        id_ready = 1'b0;
        #1;
        chk("stall_req", 32'(imem_bus.imem_req), 32'h0);
        chk("zw_opc2", 32'(if_opcode), 32'h4);
        chk("zw_fn2", 32'(if_funct), 32'h0);
        chk("zw_count", 32'(fetch_count), 32'h3);

        // Decode stalled: no request, word held; releasing it requests at once
        tick();
        chk("stall_req_hold", 32'(imem_bus.imem_req), 32'h0);
        chk("stall_instr", 32'(if_instr), 32'h4230);
        mem_lat  = 3;
        id_ready = 1'b1;
        #1;
        chk("unstall_req", 32'(imem_bus.imem_req), 32'h1);
        chk("unstall_addr", 32'(imem_bus.imem_addr), 32'h3);

        // 3-cycle memory: request held stable, valid the cycle after ack
        tick();
        chk("slow_req_c2", 32'(imem_bus.imem_req), 32'h1);
        chk("slow_addr_c2", 32'(imem_bus.imem_addr), 32'h3);
        chk("slow_valid_c2", 32'(if_valid), 32'h0);
        tick();
        chk("slow_addr_c3", 32'(imem_bus.imem_addr), 32'h3);
        chk("slow_ack_c3", 32'(imem_bus.imem_ack), 32'h1);
        chk("slow_valid_c3", 32'(if_valid), 32'h0);
        tick();
        chk("slow_valid", 32'(if_valid), 32'h1);
        chk("slow_instr", 32'(if_instr), 32'hA003);
        chk("slow_pc", 32'(if_pc), 32'h3);
        chk("slow_count", 32'(fetch_count), 32'h4);

        // Read of 4 completes, then address 5 goes out
        tick();
        tick();
        tick();
        chk("rd5_addr", 32'(imem_bus.imem_addr), 32'h5);
        chk("rd5_count", 32'(fetch_count), 32'h5);

        // Redirect to 0x40 while read of 5 is in WAIT
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        #1;
        chk("redir_addr_c2", 32'(imem_bus.imem_addr), 32'h5);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("drain_req", 32'(imem_bus.imem_req), 32'h1);
        chk("drain_addr", 32'(imem_bus.imem_addr), 32'h5);
        chk("drain_valid", 32'(if_valid), 32'h0);
        tick();
        chk("post_drain_addr", 32'(imem_bus.imem_addr), 32'h40);
        chk("post_drain_valid", 32'(if_valid), 32'h0);
        chk("post_drain_count", 32'(fetch_count), 32'h5);
        tick();
        tick();
        tick();
        chk("tgt_instr", 32'(if_instr), 32'hA040);
        chk("tgt_pc", 32'(if_pc), 32'h40);
        chk("tgt_count", 32'(fetch_count), 32'h6);

        // Redirect to 0x10 in the same cycle as an ack, with if_valid=1
        mem_lat        = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        #1;
        chk("ackredir_valid", 32'(if_valid), 32'h1);
        chk("ackredir_ack", 32'(imem_bus.imem_ack), 32'h1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("ackredir_valid_next", 32'(if_valid), 32'h0);
        chk("ackredir_addr", 32'(imem_bus.imem_addr), 32'h10);
        chk("ackredir_count", 32'(fetch_count), 32'h6);

        // PC wrap from 0xFFFF
        tick();
        chk("wrap_pre_count", 32'(fetch_count), 32'h7);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr_ffff", 32'(imem_bus.imem_addr), 32'hFFFF);
        tick();
        chk("wrap_addr_0", 32'(imem_bus.imem_addr), 32'h0);
        chk("wrap_if_pc", 32'(if_pc), 32'hFFFF);
        chk("wrap_instr", 32'(if_instr), 32'hA0FF);
        chk("wrap_count", 32'(fetch_count), 32'h8);

        // Reset asserted mid-WAIT
        tick();
        mem_lat = 3;
        #1;
        chk("prewait_addr", 32'(imem_bus.imem_addr), 32'h1);
        tick();
        chk("wait_req", 32'(imem_bus.imem_req), 32'h1);
        chk("wait_addr", 32'(imem_bus.imem_addr), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_bus.imem_req), 32'h0);
        chk("midrst_addr", 32'(imem_bus.imem_addr), 32'h0);
        chk("midrst_valid", 32'(if_valid), 32'h0);
        chk("midrst_count", 32'(fetch_count), 32'h0);

        #5;
        rst_n = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the 16-bit processor, directly upstream of `control_unit`. Owns the program counter and issues one-outstanding word reads to instruction memory. Holds the fetched word in an IF/ID register with a valid/ready handshake to decode, and presents `opcode`/`function_code` slices to the control unit. Accepts a single redirect port (taken branch or jump resolved downstream) that flushes wrong-path work, including an in-flight memory read.

## Interface
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: read request; once raised, held high with `imem_addr` stable until `imem_ack`.
- `imem_addr` out ADDR_W: word address of the request.
- `imem_ack` in 1: read complete; `imem_rdata` is valid this cycle. Zero-wait (same-cycle) ack is legal.
- `imem_rdata` in 16: instruction word.
- `redirect_valid` in 1: one-cycle pulse; take `redirect_pc` as the next PC.
- `redirect_pc` in ADDR_W: branch/jump target.
- `if_valid` out 1: IF/ID register holds a live instruction.
- `id_ready` in 1: decode consumes the IF/ID entry this cycle when `if_valid`.
- `if_instr` out 16: fetched word.
- `if_pc` out ADDR_W: address of `if_instr`.
- `if_opcode` out 4: `if_instr[15:12]`, to `control_unit.opcode`.
- `if_funct` out 4: `if_instr[3:0]`, to `control_unit.function_code`.
- `fetch_count` out 16: delivered-instruction counter.

## Operation
- Registered state: `pc`, FSM state, IF/ID register (`if_valid`, `if_instr`, `if_pc`), `fetch_count`.
- FSM states and behaviour:
  - **BOOT**: reset state, `imem_req`=0; moves to FETCH on the first clock edge after `rst_n` is high.
  - **FETCH**: `imem_req` = `!if_valid || id_ready` (slot empty or emptying), `imem_addr`=`pc`.
    - Req without ack -> WAIT.
    - Req with ack -> accept the word, stay in FETCH.
  - **WAIT**: `imem_req`=1, `imem_addr` held. Ack -> accept, go to FETCH.
  - **DRAIN**: `imem_req`=1, `imem_addr` holds the cancelled address. Ack -> data dropped, go to FETCH.
- Accept (ack, not dropped):
  - `if_instr`←`imem_rdata`, `if_pc`←`pc`, `if_valid`←1.
  - `pc`←`pc+1` (wraps FFFF->0000).
  - `fetch_count`←`fetch_count+1` (wraps).
- Invariant: while in WAIT the IF/ID slot is empty, so an ack can always be accepted. No skid buffer is needed.
- Consume: `if_valid && id_ready` with no accept that cycle -> `if_valid`←0.
- Redirect (highest priority, any state except BOOT):
  - `pc`←`redirect_pc`; `if_valid`←0 regardless of `id_ready`; any ack that cycle is dropped.
  - Next state depends on the current request:
    - Outstanding request not acked this cycle -> DRAIN. This includes a FETCH cycle with the request raised, as well as WAIT.
    - Acked this cycle, or no request -> FETCH.
  - In DRAIN, a further redirect only overwrites `pc`.
- Dropped words never increment `fetch_count`.

## Timing
- Reset values: `pc`=`RESET_PC`, state BOOT, `if_valid`=0, `if_instr`=16'h0000, `if_pc`=0, `fetch_count`=0, `imem_req`=0. Reset is asynchronous mid-operation: an outstanding request is abandoned.
- `imem_req` and `imem_addr` are combinational from state, `pc`, `if_valid` and `id_ready`.
- Latency: ack in cycle n -> `if_valid`=1 in cycle n+1.
- Throughput: with zero-wait memory and `id_ready`=1, one instruction per cycle.
- Redirect in cycle n -> `if_valid`=0 in n+1, and the earliest request to `redirect_pc` is also in n+1.

## Structure
- Shared package `cpu16_pkg`:
  - `INSTR_W`=16.
  - Opcode/funct field bounds (`OPC_HI`=15, `OPC_LO`=12, `FN_HI`=3, `FN_LO`=0).
  - Fetch-state enum (BOOT, FETCH, WAIT, DRAIN).
  - Default `RESET_PC`.
- Single module; no sub-module.

## Test plan
- Reset release, zero-wait memory returning 16'h0012, 16'h3105, 16'h4230 at addresses 0..2, `id_ready`=1:
  - `imem_addr` sequences 0,1,2 on consecutive cycles.
  - `if_opcode` = 0,3,4 one cycle after each ack.
  - `fetch_count`=3.
- Memory with 3-cycle ack: `imem_req`/`imem_addr` stay stable for 3 cycles; `if_valid` rises the cycle after ack.
- `id_ready`=0 with `if_valid`=1:
  - No request issued, `if_instr` held.
  - Raising `id_ready` issues a request that same cycle.
- Redirect to 16'h0040 while a 3-cycle read of address 5 is outstanding:
  - `imem_addr` stays 5 until ack.
  - That word is dropped, `fetch_count` is unchanged.
  - The next request goes to 16'h0040.
- Redirect to 16'h0010 in the same cycle as an ack, with `if_valid`=1: `if_valid`=0 next cycle and the next request is to 16'h0010.
- PC at 16'hFFFF, accept: next `imem_addr`=16'h0000; reset asserted mid-WAIT -> `imem_req`=0 immediately, `pc`=`RESET_PC`.
